// File: rtl/fetch_sequencer_pkg.sv
// Shared constants, FSM state encoding and address helpers for the fetch sequencer.
package fetch_sequencer_pkg;

    localparam int INSTR_SIZE      = 32;
    localparam int PC_STEP_DEFAULT = 4;
    localparam logic [INSTR_SIZE-1:0] INSTR_SIZE_ZEROS = '0;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_DRAIN = 3'd3,
        FS_HALT  = 3'd4
    } fs_state_t;

    function automatic logic misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Single-entry valid/ready holding register between fetch and decode, with flush.
module fetch_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         flush,
    input  logic [W-1:0] load_instr,
    input  logic [W-1:0] load_pc,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] instr,
    output logic [W-1:0] instr_pc
);

    // Flush wins over a pending transfer; the transfer itself still happens this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid    <= 1'b0;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
            else if (ready)
                valid <= 1'b0;

            if (load && !flush) begin
                instr    <= load_instr;
                instr_pc <= load_pc;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage sequencer: owns the PC, issues IMEM requests, applies redirects and halts on faults.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int XLEN    = INSTR_SIZE,
    parameter int PC_STEP = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] entry_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] redirect_offset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            fault
);

    fs_state_t       state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] target, pc_incr;
    logic            fault_next;
    logic            can_issue, req_fire, redirect_take;
    logic            load, flush;

    assign target    = redirect_base + redirect_offset;
    assign pc_incr   = pc + XLEN'(PC_STEP);

    // Only one word may be in flight, so a request needs a free (or draining) output slot.
    assign can_issue      = !instr_valid || instr_ready;
    assign imem_req_valid = (state == FS_REQ) && can_issue;
    assign imem_req_addr  = (state == FS_REQ) ? pc : XLEN'(INSTR_SIZE_ZEROS);
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign redirect_take = redirect_valid &&
                           (state == FS_REQ || state == FS_WAIT || state == FS_DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FS_IDLE;
            pc    <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            fault <= fault_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        fault_next = fault;
        load       = 1'b0;
        flush      = (state == FS_HALT);

        if (redirect_take) begin
            flush = 1'b1;
            if (misaligned(target[1:0])) begin
                fault_next = 1'b1;
                state_next = FS_HALT;
            end else begin
                pc_next = target;
                // Any response tied to the old stream must be swallowed by DRAIN.
                case (state)
                    FS_REQ:   state_next = req_fire       ? FS_DRAIN : FS_REQ;
                    FS_WAIT:  state_next = imem_rsp_valid ? FS_REQ   : FS_DRAIN;
                    FS_DRAIN: state_next = imem_rsp_valid ? FS_REQ   : FS_DRAIN;
                    default:  state_next = state;
                endcase
            end
        end else begin
            case (state)
                FS_IDLE: begin
                    if (start) begin
                        pc_next    = entry_pc;
                        state_next = FS_REQ;
                    end
                end
                FS_REQ: begin
                    if (req_fire)
                        state_next = FS_WAIT;
                end
                FS_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (imem_rsp_err) begin
                            fault_next = 1'b1;
                            state_next = FS_HALT;
                        end else begin
                            load       = 1'b1;
                            pc_next    = pc_incr;
                            state_next = FS_REQ;
                        end
                    end
                end
                FS_DRAIN: begin
                    if (imem_rsp_valid)
                        state_next = FS_REQ;
                end
                default: state_next = state;
            endcase
        end
    end

    fetch_out_reg #(
        .W (XLEN)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .flush      (flush),
        .load_instr (imem_rsp_data),
        .load_pc    (pc),
        .ready      (instr_ready),
        .valid      (instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer with a budgeted, one-cycle-latency IMEM model.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] entry_pc = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_base = '0;
    logic [31:0] redirect_offset = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          budget = 0;
    logic        rsp_hold = 1'b0;
    logic        pend_valid = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .entry_pc        (entry_pc),
        .redirect_valid  (redirect_valid),
        .redirect_base   (redirect_base),
        .redirect_offset (redirect_offset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .imem_rsp_err    (imem_rsp_err),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .fault           (fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%h required=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%b required=%b", tag, got, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.data = mem_word(a);
        sb.push_back(e);
    endtask

    task automatic set_budget(input int n);
        budget         = n;
        imem_req_ready = (n > 0);
    endtask

    // One clock: sample at negedge, then after the edge drive IMEM response and clear pulses.
    task automatic step();
        logic        acc;
        logic [31:0] acc_addr;
        exp_t        e;
        @(negedge clk);
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        if (instr_valid && instr_ready) begin
            vectors++;
            assert (sb.size() > 0) else begin
                miscompares++;
                $error("FAIL deliv_unexpected got pc=%h required none", instr_pc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("deliv_pc", instr_pc, e.pc);
                chk("deliv_instr", instr, e.data);
            end
        end
        @(posedge clk);
        #1;
        start          = 1'b0;
        redirect_valid = 1'b0;
        if (acc) begin
            pend_valid = 1'b1;
            pend_addr  = acc_addr;
            if (budget > 0) budget--;
        end
        imem_req_ready = (budget > 0);
        if (pend_valid && !rsp_hold) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
            imem_rsp_err   = err_en && (pend_addr == err_addr);
            pend_valid     = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            imem_rsp_err   = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk1({tag, "_req_valid"}, imem_req_valid, 1'b0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
        chk1({tag, "_instr_valid"}, instr_valid, 1'b0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_instr_pc"}, instr_pc, 32'h0);
        chk1({tag, "_fault"}, fault, 1'b0);
        pend_valid     = 1'b0;
        rsp_hold       = 1'b0;
        err_en         = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        set_budget(0);
        step();
        rst = 1'b1;
    endtask

    initial begin
        #2;
        do_reset("rst0");

        // Sequential fetch and first-delivery latency
        instr_ready = 1'b1;
        entry_pc    = 32'h100;
        set_budget(3);
        expect_fetch(32'h100);
        expect_fetch(32'h104);
        expect_fetch(32'h108);
        chk1("t1_idle_noreq", imem_req_valid, 1'b0);
        start = 1'b1;
        step();
        chk1("t1_req_valid_t1", imem_req_valid, 1'b1);
        chk("t1_req_addr_t1", imem_req_addr, 32'h100);
        step();
        chk1("t1_no_instr_t2", instr_valid, 1'b0);
        step();
        chk1("t1_instr_valid_t3", instr_valid, 1'b1);
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        chk("t1_all_delivered", sb.size(), 0);
        step();
        step();
        chk("t1_next_addr", imem_req_addr, 32'h10C);
        chk1("t1_idle_out", instr_valid, 1'b0);

        // Decode stall holds the word and blocks further requests
        instr_ready = 1'b0;
        set_budget(2);
        expect_fetch(32'h10C);
        expect_fetch(32'h110);
        for (int i = 0; i < 20 && !instr_valid; i++) step();
        chk1("t2_first_valid", instr_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("t2_hold_valid", instr_valid, 1'b1);
            chk("t2_hold_pc", instr_pc, 32'h10C);
            chk1("t2_no_req", imem_req_valid, 1'b0);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        chk("t2_all_delivered", sb.size(), 0);

        // Redirect in WAIT with no response yet: stale response dropped
        rsp_hold = 1'b1;
        set_budget(1);
        for (int i = 0; i < 20 && !pend_valid; i++) step();
        chk1("t3_in_flight", pend_valid, 1'b1);
        redirect_valid  = 1'b1;
        redirect_base   = 32'h200;
        redirect_offset = 32'h40;
        step();
        chk1("t3_drain_noreq", imem_req_valid, 1'b0);
        rsp_hold = 1'b0;
        set_budget(1);
        expect_fetch(32'h240);
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        chk("t3_target_delivered", sb.size(), 0);

        // Redirect in WAIT with the response in the same cycle
        set_budget(1);
        for (int i = 0; i < 20 && !imem_rsp_valid; i++) step();
        chk1("t3b_rsp_now", imem_rsp_valid, 1'b1);
        redirect_valid  = 1'b1;
        redirect_base   = 32'h300;
        redirect_offset = 32'h0;
        set_budget(1);
        expect_fetch(32'h300);
        step();
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        chk("t3b_target_delivered", sb.size(), 0);

        // Redirect while a held word transfers: delivered once, then flushed
        instr_ready = 1'b0;
        set_budget(1);
        expect_fetch(32'h304);
        for (int i = 0; i < 20 && !instr_valid; i++) step();
        chk1("t3c_held", instr_valid, 1'b1);
        chk1("t3c_stall_noreq", imem_req_valid, 1'b0);
        instr_ready     = 1'b1;
        redirect_valid  = 1'b1;
        redirect_base   = 32'h400;
        redirect_offset = 32'h10;
        step();
        chk("t3c_transferred", sb.size(), 0);
        chk1("t3c_flushed", instr_valid, 1'b0);
        chk1("t3c_req_valid", imem_req_valid, 1'b1);
        chk("t3c_req_addr", imem_req_addr, 32'h410);

        // Misaligned redirect halts permanently
        redirect_valid  = 1'b1;
        redirect_base   = 32'h200;
        redirect_offset = 32'h2;
        step();
        chk1("t4_fault", fault, 1'b1);
        chk1("t4_no_req", imem_req_valid, 1'b0);
        chk1("t4_no_instr", instr_valid, 1'b0);
        set_budget(3);
        entry_pc = 32'h100;
        start    = 1'b1;
        step();
        redirect_valid  = 1'b1;
        redirect_base   = 32'h200;
        redirect_offset = 32'h40;
        step();
        for (int i = 0; i < 4; i++) step();
        chk1("t4_still_fault", fault, 1'b1);
        chk1("t4_still_no_req", imem_req_valid, 1'b0);
        chk1("t4_still_no_instr", instr_valid, 1'b0);
        chk("t4_none_delivered", sb.size(), 0);
        do_reset("t4_rst");

        // IMEM error on the third response
        entry_pc = 32'h1000;
        err_en   = 1'b1;
        err_addr = 32'h1008;
        set_budget(3);
        expect_fetch(32'h1000);
        expect_fetch(32'h1004);
        start = 1'b1;
        step();
        for (int i = 0; i < 60 && !fault; i++) step();
        chk1("t5_fault", fault, 1'b1);
        chk("t5_two_delivered", sb.size(), 0);
        for (int i = 0; i < 3; i++) step();
        chk1("t5_no_instr", instr_valid, 1'b0);
        chk1("t5_no_req", imem_req_valid, 1'b0);
        do_reset("t5_rst");
        for (int i = 0; i < 3; i++) step();
        chk1("t5_idle_noreq", imem_req_valid, 1'b0);

        // PC wrap, then asynchronous reset while waiting on IMEM
        entry_pc = 32'hFFFF_FFFC;
        set_budget(3);
        expect_fetch(32'hFFFF_FFFC);
        expect_fetch(32'h0000_0000);
        expect_fetch(32'h0000_0004);
        start = 1'b1;
        step();
        for (int i = 0; i < 60 && sb.size() != 0; i++) step();
        chk("t6_wrap_delivered", sb.size(), 0);
        rsp_hold = 1'b1;
        set_budget(1);
        for (int i = 0; i < 20 && !pend_valid; i++) step();
        chk1("t6_in_flight", pend_valid, 1'b1);
        chk("t6_last_pc", instr_pc, 32'h4);
        do_reset("t6_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
